// File: rtl/animation_pkg.sv
// Shared constants and state type for the ladder reveal animation.
package animation_pkg;

  localparam int unsigned ANIM_FRAMES_PER_STEP = 8;
  localparam logic [3:0]  ANIM_LADDER_START    = 4'd15;

  typedef enum logic [1:0] {IDLE, RUN, DONE} anim_state_t;

endpackage

// File: rtl/vga_if.sv
// VGA timing bundle passed between pipeline stages.
interface vga_if;

  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);

endinterface

// File: rtl/edge_detect.sv
// Rising-edge detector with a configurable reset level for the delayed copy.
module edge_detect #(
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_rise
);

  logic r_sig;

  // Resetting to 1 suppresses a false edge when the input is already high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig <= RESET_LEVEL;
    end else begin
      r_sig <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_sig;

endmodule

// File: rtl/animation_ladder_ctl.sv
// Ladder reveal sequencer: counts vblank frames and steps the hidden-row count
// down until all ladders are drawn, then pulses done.
module animation_ladder_ctl
  import animation_pkg::*;
#(
  parameter int unsigned FRAMES_PER_STEP = ANIM_FRAMES_PER_STEP,
  parameter int unsigned START_COUNT     = ANIM_LADDER_START
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_en,
  vga_if.in          in,
  output logic       animation,
  output logic [3:0] counter,
  output logic       done
);

  localparam logic [3:0] START_CNT = 4'(START_COUNT);
  localparam logic [7:0] STEP_CNT  = 8'(FRAMES_PER_STEP);

  anim_state_t r_state, w_state_d;
  logic [7:0]  r_frame_cnt, w_frame_cnt_d;
  logic [7:0]  w_frame_inc;
  logic [3:0]  r_counter, w_counter_d;
  logic        r_anim, w_anim_d;
  logic        r_done, w_done_d;
  logic        w_tick;

  edge_detect #(
    .RESET_LEVEL(1'b1)
  ) u_vblnk_edge (
    .clk   (clk),
    .rst   (rst),
    .i_sig (in.vblnk),
    .o_rise(w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_frame_cnt <= '0;
      r_counter   <= START_CNT;
      r_anim      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_frame_cnt <= w_frame_cnt_d;
      r_counter   <= w_counter_d;
      r_anim      <= w_anim_d;
      r_done      <= w_done_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_frame_cnt_d = r_frame_cnt;
    w_counter_d   = r_counter;
    w_anim_d      = r_anim;
    w_done_d      = 1'b0;
    w_frame_inc   = r_frame_cnt + 8'd1;

    unique case (r_state)
      IDLE: begin
        w_anim_d      = 1'b0;
        w_counter_d   = START_CNT;
        w_frame_cnt_d = '0;
        if (game_en) begin
          w_state_d = RUN;
          w_anim_d  = 1'b1;
        end
      end

      RUN: begin
        // Abort takes priority over a coincident step tick.
        if (!game_en) begin
          w_state_d     = IDLE;
          w_anim_d      = 1'b0;
          w_counter_d   = START_CNT;
          w_frame_cnt_d = '0;
        end else if (w_tick) begin
          if (w_frame_inc == STEP_CNT) begin
            w_frame_cnt_d = '0;
            if (r_counter != 4'd0) begin
              w_counter_d = r_counter - 4'd1;
            end else begin
              w_state_d = DONE;
              w_anim_d  = 1'b0;
              w_done_d  = 1'b1;
            end
          end else begin
            w_frame_cnt_d = w_frame_inc;
          end
        end
      end

      DONE: begin
        w_anim_d      = 1'b0;
        w_counter_d   = 4'd0;
        w_frame_cnt_d = '0;
        if (!game_en) begin
          w_state_d   = IDLE;
          w_counter_d = START_CNT;
        end
      end

      default: begin
        w_state_d     = IDLE;
        w_anim_d      = 1'b0;
        w_counter_d   = START_CNT;
        w_frame_cnt_d = '0;
      end
    endcase
  end

  assign animation = r_anim;
  assign counter   = r_counter;
  assign done      = r_done;

endmodule

// File: tb/tb_animation_ladder_ctl.sv
// Bench for animation_ladder_ctl: two instances (2/3 and 1/0) against a frame-count model.
module tb_animation_ladder_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic       game_en;
  logic       anim_a, done_a, anim_b, done_b;
  logic [3:0] cnt_a, cnt_b;

  vga_if u_vga ();

  animation_ladder_ctl #(
    .FRAMES_PER_STEP(2),
    .START_COUNT    (3)
  ) u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .game_en  (game_en),
    .in       (u_vga),
    .animation(anim_a),
    .counter  (cnt_a),
    .done     (done_a)
  );

  animation_ladder_ctl #(
    .FRAMES_PER_STEP(1),
    .START_COUNT    (0)
  ) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .game_en  (game_en),
    .in       (u_vga),
    .animation(anim_b),
    .counter  (cnt_b),
    .done     (done_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit vb_auto  = 1'b1;
  bit vb_man   = 1'b0;
  bit drop_on_pulse = 1'b0;
  int pulses_a = 0;
  int pulses_b = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
  endtask

  // Model: phase 0=idle 1=run 2=done; n = ticks seen since entering run.
  int m_fps   [2] = '{2, 1};
  int m_start [2] = '{3, 0};
  int m_ph    [2];
  int m_n     [2];
  bit m_done  [2];
  bit m_vprev;

  function automatic int exp_cnt(input int ph, input int n, input int fps, input int st);
    if (ph == 0) return st;
    if (ph == 1) return st - n / fps;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit tk;
    int ph, n;
    bit dn;
    if (rst) begin
      m_vprev <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_ph[i]   <= 0;
        m_n[i]    <= 0;
        m_done[i] <= 1'b0;
      end
    end else begin
      tk = u_vga.vblnk & ~m_vprev;
      m_vprev <= u_vga.vblnk;
      for (int i = 0; i < 2; i++) begin
        ph = m_ph[i];
        n  = m_n[i];
        dn = 1'b0;
        if (ph == 0) begin
          if (game_en) begin ph = 1; n = 0; end
        end else if (ph == 1) begin
          if (!game_en) ph = 0;
          else if (tk) begin
            n++;
            if (n == (m_start[i] + 1) * m_fps[i]) begin ph = 2; dn = 1'b1; end
          end
        end else begin
          if (!game_en) ph = 0;
        end
        m_ph[i]   <= ph;
        m_n[i]    <= n;
        m_done[i] <= dn;
      end
    end
  end

  always @(negedge clk) begin
    chk("a_animation", int'(anim_a), int'(m_ph[0] == 1));
    chk("a_counter",   int'(cnt_a),  exp_cnt(m_ph[0], m_n[0], m_fps[0], m_start[0]));
    chk("a_done",      int'(done_a), int'(m_done[0]));
    chk("b_animation", int'(anim_b), int'(m_ph[1] == 1));
    chk("b_counter",   int'(cnt_b),  exp_cnt(m_ph[1], m_n[1], m_fps[1], m_start[1]));
    chk("b_done",      int'(done_b), int'(m_done[1]));
    if (done_a) pulses_a <= pulses_a + 1;
    if (done_b) pulses_b <= pulses_b + 1;
  end

  task automatic step1();
    @(posedge clk);
    #2;
    cyc++;
    u_vga.vblnk = vb_auto ? (cyc % 20 == 0) : vb_man;
    if (drop_on_pulse && u_vga.vblnk) begin
      game_en = 1'b0;
      drop_on_pulse = 1'b0;
    end
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step1();
  endtask

  // Advance until k vblank pulses were driven, then one more cycle so they land.
  task automatic frames(input int k);
    int seen = 0;
    int guard = 0;
    while (seen < k && guard < 20 * k + 40) begin
      step1();
      if (u_vga.vblnk) seen++;
      guard++;
    end
    chk("frame_budget", seen, k);
    step1();
  endtask

  initial begin
    int pa, pb;
    u_vga.hcount = '0;
    u_vga.vcount = '0;
    u_vga.hsync  = 1'b0;
    u_vga.vsync  = 1'b0;
    u_vga.hblnk  = 1'b0;
    u_vga.vblnk  = 1'b0;
    rst = 1'b1;
    game_en = 1'b0;
    steps(3);
    rst = 1'b0;
    chk("rst_anim", int'(anim_a), 0);
    chk("rst_cnt", int'(cnt_a), 3);
    chk("rst_done", int'(done_a), 0);
    chk("rst_cnt_b", int'(cnt_b), 0);

    // Idle for 5 frames
    pa = pulses_a;
    frames(5);
    chk("idle_anim", int'(anim_a), 0);
    chk("idle_cnt", int'(cnt_a), 3);
    step1();
    chk("idle_no_done", pulses_a - pa, 0);

    // Full sequence
    pa = pulses_a;
    pb = pulses_b;
    game_en = 1'b1;
    step1();
    chk("start_anim", int'(anim_a), 1);
    chk("start_cnt", int'(cnt_a), 3);
    frames(2);
    chk("f2_cnt", int'(cnt_a), 2);
    chk("b_done_once", pulses_b - pb, 1);
    chk("b_anim_off", int'(anim_b), 0);
    frames(2);
    chk("f4_cnt", int'(cnt_a), 1);
    frames(2);
    chk("f6_cnt", int'(cnt_a), 0);
    chk("f6_anim", int'(anim_a), 1);
    frames(1);
    chk("f7_anim", int'(anim_a), 1);
    frames(1);
    chk("f8_anim", int'(anim_a), 0);
    chk("f8_done", int'(done_a), 1);
    chk("f8_cnt", int'(cnt_a), 0);
    step1();
    chk("f8_done_low", int'(done_a), 0);
    chk("one_done", pulses_a - pa, 1);
    game_en = 1'b0;
    step1();
    chk("reload_cnt", int'(cnt_a), 3);

    // Abort after frame 3
    pa = pulses_a;
    game_en = 1'b1;
    step1();
    frames(3);
    chk("abort_pre_cnt", int'(cnt_a), 2);
    game_en = 1'b0;
    step1();
    chk("abort_anim", int'(anim_a), 0);
    chk("abort_cnt", int'(cnt_a), 3);
    step1();
    chk("abort_no_done", pulses_a - pa, 0);
    game_en = 1'b1;
    step1();
    frames(8);
    chk("restart_done", int'(done_a), 1);
    chk("restart_anim", int'(anim_a), 0);
    step1();

    // Async reset mid-run at counter 1
    game_en = 1'b0;
    step1();
    game_en = 1'b1;
    step1();
    frames(4);
    chk("pre_rst_cnt", int'(cnt_a), 1);
    rst = 1'b1;
    #1;
    chk("async_anim", int'(anim_a), 0);
    chk("async_cnt", int'(cnt_a), 3);
    chk("async_done", int'(done_a), 0);
    steps(2);
    rst = 1'b0;
    step1();
    chk("rst_restart_anim", int'(anim_a), 1);

    // vblnk held high across reset release
    vb_auto = 1'b0;
    vb_man = 1'b1;
    step1();
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    steps(5);
    chk("vbh_anim", int'(anim_a), 1);
    chk("vbh_no_tick", int'(cnt_a), 3);
    vb_man = 1'b0;
    step1();
    vb_man = 1'b1;
    steps(2);
    chk("vbh_edge1", int'(cnt_a), 3);
    vb_man = 1'b0;
    step1();
    vb_man = 1'b1;
    steps(2);
    chk("vbh_edge2", int'(cnt_a), 2);

    // game_en drop coinciding with a step tick
    vb_auto = 1'b1;
    game_en = 1'b0;
    step1();
    for (int i = 0; i < 25 && cyc % 20 != 1; i++) step1();
    game_en = 1'b1;
    step1();
    frames(1);
    pa = pulses_a;
    drop_on_pulse = 1'b1;
    frames(1);
    chk("coinc_anim", int'(anim_a), 0);
    chk("coinc_cnt", int'(cnt_a), 3);
    chk("coinc_done", int'(done_a), 0);
    step1();
    chk("coinc_no_done", pulses_a - pa, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/animation_ladder_ctl.md
# animation_ladder_ctl

Sequencer for the game-start ladder reveal. It sits directly upstream of the ladder animation renderer and drives that stage's `animation` and `counter` inputs. It counts video frames from the vblank edge of the incoming VGA timing and steps `counter` down once every `FRAMES_PER_STEP` frames, revealing one 32-pixel ladder row per step. It drops `animation` and pulses `done` once the ladders are fully drawn.

## Interface

Parameters:
- `FRAMES_PER_STEP`, default `ANIM_FRAMES_PER_STEP` (8): frames per counter step; legal range 1..255.
- `START_COUNT`, default `ANIM_LADDER_START` (15): initial `counter` value, i.e. number of hidden ladder rows; legal range 0..15.

Ports:
- `clk`, input, 1: pixel clock.
- `rst`, input, 1: asynchronous reset, active-high.
- `game_en`, input, 1: game running; a level-high in IDLE starts the sequence.
- `in`, `vga_if.in`, -: timing source; only `in.vblnk` is used.
- `animation`, output, 1: high while the reveal is in progress.
- `counter`, output, 4: hidden-ladder count; the renderer shows rows with vcount ≤ VER_PIXELS − 32·counter.
- `done`, output, 1: one-cycle pulse when the sequence completes.

## Operation

- Frame tick: rising edge of `in.vblnk`, detected against a registered copy `vblnk_q`, so `tick = in.vblnk & ~vblnk_q`. `vblnk_q` resets to 1, so a vblnk that is high out of reset does not produce a tick.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Outputs: `animation` = 0, `counter` = `START_COUNT`, `frame_cnt` = 0.
  - If `game_en` = 1, go to RUN. `animation` is 1 from the next cycle.
- RUN:
  - Each tick increments `frame_cnt`.
  - On the tick that makes `frame_cnt` = `FRAMES_PER_STEP` (the step tick), `frame_cnt` clears. Then:
    - if `counter` > 0, decrement `counter`;
    - if `counter` = 0, go to DONE, set `animation` to 0 and set `done` to 1 for one cycle.
  - Total reveal lasts (`START_COUNT` + 1)·`FRAMES_PER_STEP` frames, so the fully drawn state (`counter` = 0) is held for one full step.
- DONE:
  - Outputs: `animation` = 0, `counter` = 0.
  - Stays here while `game_en` = 1.
  - `game_en` = 0 → IDLE, which reloads `counter` = `START_COUNT`.
- `game_en` falling while in RUN: next cycle returns to IDLE, `animation` = 0, `counter` reloaded, no `done` pulse.
- `game_en` = 0 coinciding with a step tick: abort wins; no decrement, no `done`.
- `counter` never wraps: no decrement below 0 and no increment path exists.
- `START_COUNT` = 0: RUN with `counter` = 0, then DONE after `FRAMES_PER_STEP` frames.

## Timing

- All outputs are registered; there is no combinational input→output path.
- Reset values: `animation` = 0, `counter` = `START_COUNT`, `done` = 0, state = IDLE, `frame_cnt` = 0, `vblnk_q` = 1.
- Tick latency:
  - `in.vblnk` rising at cycle N gives tick at cycle N.
  - A resulting `counter` or `animation` change is visible at N+1.
  - `done` is high for exactly cycle N+1.
- Start latency: `game_en` high at cycle M (state IDLE) gives `animation` = 1 at M+1.
- Reset asserted mid-RUN: outputs go to their reset values immediately (asynchronously). After release, the block waits in IDLE and restarts at once if `game_en` is still high.
- `counter` changes only at frame starts (vblank), so the renderer never sees a mid-frame height change.

## Structure

- `animation_pkg` additions:
  - `ANIM_FRAMES_PER_STEP` = 8
  - `ANIM_LADDER_START` = 4'd15
  - typedef `anim_state_t` enum {IDLE, RUN, DONE}
- `LADDER_HEIGHT` and `VER_PIXELS` remain in `ladder_pkg` / `vga_pkg`; this block does no pixel arithmetic.
- One sub-module, `edge_detect` (rising-edge, async reset, configurable reset level), instantiated for `in.vblnk`.
- `frame_cnt` is 8 bits; the compare is against `8'(FRAMES_PER_STEP)`.

## Test plan

Bench parameters: `FRAMES_PER_STEP` = 2, `START_COUNT` = 3; vblank is modelled as a 1-cycle-high pulse every 20 cycles.

- Reset, then `game_en` held 0 for 5 frames → `animation` = 0, `counter` = 3, `done` never asserts.
- `game_en` = 1 → `animation` = 1 next cycle. `counter` sequence is 3, 2, 1, 0, with changes on frames 2, 4 and 6. On frame 8 `animation` = 0 and `done` is a 1-cycle pulse; `counter` stays 0.
- `game_en` dropped after frame 3 (`counter` = 2) → next cycle `animation` = 0, `counter` = 3, no `done`. Re-raising `game_en` restarts the full 8-frame sequence.
- `rst` pulsed asynchronously mid-RUN with `counter` = 1 → outputs are 0/3/0 before the next clock edge. The sequence restarts after release because `game_en` = 1.
- `in.vblnk` held high across reset release → no tick until vblnk falls and rises again; first decrement is two genuine edges later.
- `START_COUNT` = 0, `FRAMES_PER_STEP` = 1 → `animation` high for exactly 1 frame, `done` pulse on the first tick, `counter` constant at 0.
